// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI flash read sequencer and the SPI byte engine
// it drives:
//   - SPI_STAGE_DONE : engine stage value meaning "byte complete"
//   - flash opcodes and the MOSI filler byte
//   - sequencer state encoding
// ----------------------------------------------------------------------------
package spi_pkg;

  localparam logic [7:0] SPI_STAGE_DONE = 8'd99;
  localparam logic [7:0] CMD_READ_DEF   = 8'h03;
  localparam logic [7:0] CMD_FAST_DEF   = 8'h0B;
  localparam logic [7:0] IDLE_BYTE_DEF  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OPEN      = 3'd1,
    ST_WAIT_GO   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4,
    ST_PRESENT   = 3'd5,
    ST_CLOSE     = 3'd6
  } rd_state_e;

endpackage

// File: rtl/spi_flash_reader.sv
// ----------------------------------------------------------------------------
// spi_flash_reader
// Command sequencer sitting directly upstream of the SPI byte engine. On a
// start request it opens a flash read (opcode + address, MSB byte first) and
// streams LEN received data bytes out over a valid/ready port. Used to load
// calibration / FPGA tables from serial flash at boot.
//
// Build option: define SPI_FLASH_FAST_READ_EN to use the fast-read opcode and
// send one filler (dummy) byte after the address. Default build uses the
// plain read opcode with no dummy byte.
//
// Ports
//   clk_in            : system clock, same domain as the SPI byte engine
//   reset_n           : asynchronous active-low reset
//   start             : 1-cycle request; samples addr and len (ignored while busy)
//   addr  [ADDR_W]    : flash start address
//   len   [LEN_W]     : bytes to read; 0 = no transaction, just a done pulse
//   abort             : terminate the current transaction
//   busy              : high from accepted start until the done pulse
//   done              : 1-cycle pulse when the transaction is closed
//   rd_data [8]       : received data byte
//   rd_valid          : rd_data valid; held until rd_ready
//   rd_ready          : downstream accepts rd_data
//   spi_enabled       : engine enable (low = CS high, engine reset)
//   spi_data_in [8]   : byte for the engine to shift out
//   spi_continue_read : 1-cycle pulse asking the engine for the next byte
//   spi_data_out [8]  : byte received by the engine
//   spi_stage [8]     : engine stage; SPI_STAGE_DONE = byte complete
// ----------------------------------------------------------------------------
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter int         ADDR_W    = 24,
  parameter int         LEN_W     = 16,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0] CMD_FAST  = CMD_FAST_DEF,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              spi_enabled,
  output logic [7:0]        spi_data_in,
  output logic              spi_continue_read,
  input  logic [7:0]        spi_data_out,
  input  logic [7:0]        spi_stage
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int DUMMY_N = 1;
  localparam bit FAST_EN = 1'b1;
`else
  localparam int DUMMY_N = 0;
  localparam bit FAST_EN = 1'b0;
`endif

  localparam logic [7:0] OPCODE     = FAST_EN ? CMD_FAST : CMD_READ;
  localparam int         ADDR_BYTES = ADDR_W / 8;
  // Header = opcode + address bytes + optional dummy byte.
  localparam int         HDR_N      = 1 + ADDR_BYTES + DUMMY_N;
  localparam int         IDX_W      = $clog2(HDR_N + 1);

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_N - 1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  // Byte sent at position idx of the transaction: opcode, address bytes MSB
  // first, then filler (covers both the dummy byte and all data-phase bytes).
  function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0]  idx,
                                          input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] sh;
    logic [7:0]        b;
    sh = a;
    b  = IDLE_BYTE;
    if (idx == IDX_ZERO) begin
      b = OPCODE;
    end else if (int'(idx) <= ADDR_BYTES) begin
      sh = a >> (ADDR_W - 8 * int'(idx));
      b  = sh[7:0];
    end else begin
      b = IDLE_BYTE;
    end
    return b;
  endfunction

  rd_state_e         state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  cnt_r;        // data bytes still to be delivered
  logic [IDX_W-1:0]  idx_r;        // position of the byte in flight, saturates at HDR_N
  logic              close_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic [7:0]        rd_data_r;
  logic              rd_valid_r;
  logic              spi_enabled_r;
  logic [7:0]        spi_data_in_r;
  logic              spi_continue_read_r;

  logic              rd_hs_s;
  logic [IDX_W-1:0]  idx_next_s;

  assign rd_hs_s = rd_valid_r & rd_ready;

  assign busy              = busy_r;
  assign done              = done_r;
  assign rd_data           = rd_data_r;
  assign rd_valid          = rd_valid_r;
  assign spi_enabled       = spi_enabled_r;
  assign spi_data_in       = spi_data_in_r;
  assign spi_continue_read = spi_continue_read_r;

  // Index of the next byte to send; once past the header it stays put so
  // every further byte is treated as a data byte.
  always_comb begin
    idx_next_s = idx_r;
    if (idx_r <= HDR_LAST) begin
      idx_next_s = idx_r + IDX_ONE;
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r             <= ST_IDLE;
      addr_r              <= {ADDR_W{1'b0}};
      cnt_r               <= LEN_ZERO;
      idx_r               <= IDX_ZERO;
      close_cnt_r         <= 1'b0;
      busy_r              <= 1'b0;
      done_r              <= 1'b0;
      rd_data_r           <= 8'h00;
      rd_valid_r          <= 1'b0;
      spi_enabled_r       <= 1'b0;
      spi_data_in_r       <= 8'hFF;
      spi_continue_read_r <= 1'b0;
    end else begin
      // Pulses default low so each is exactly one cycle wide.
      done_r              <= 1'b0;
      spi_continue_read_r <= 1'b0;

      if (abort && (state_r != ST_IDLE) && (state_r != ST_CLOSE)) begin
        // A byte accepted in the abort cycle still counts as delivered.
        if (rd_hs_s) begin
          cnt_r <= cnt_r - LEN_ONE;
        end
        rd_valid_r    <= 1'b0;
        spi_enabled_r <= 1'b0;
        close_cnt_r   <= 1'b0;
        state_r       <= ST_CLOSE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              if (len != LEN_ZERO) begin
                addr_r  <= addr;
                cnt_r   <= len;
                idx_r   <= IDX_ZERO;
                busy_r  <= 1'b1;
                state_r <= ST_OPEN;
              end else begin
                done_r  <= 1'b1;
              end
            end
          end

          ST_OPEN: begin
            // Engine starts byte 0 by itself once enabled.
            spi_data_in_r <= hdr_byte(IDX_ZERO, addr_r);
            spi_enabled_r <= 1'b1;
            state_r       <= ST_WAIT_GO;
          end

          ST_WAIT_GO: begin
            // The engine still shows the previous byte's done stage right
            // after continue_read; wait until it leaves that stage.
            if (spi_stage != SPI_STAGE_DONE) begin
              state_r <= ST_WAIT_DONE;
            end
          end

          ST_WAIT_DONE: begin
            if (spi_stage == SPI_STAGE_DONE) begin
              if (idx_r <= HDR_LAST) begin
                state_r <= ST_NEXT;
              end else begin
                rd_data_r  <= spi_data_out;
                rd_valid_r <= 1'b1;
                state_r    <= ST_PRESENT;
              end
            end
          end

          ST_NEXT: begin
            spi_data_in_r       <= hdr_byte(idx_next_s, addr_r);
            idx_r               <= idx_next_s;
            spi_continue_read_r <= 1'b1;
            state_r             <= ST_WAIT_GO;
          end

          ST_PRESENT: begin
            // SCK stays idle while the consumer stalls.
            if (rd_hs_s) begin
              rd_valid_r <= 1'b0;
              cnt_r      <= cnt_r - LEN_ONE;
              if (cnt_r == LEN_ONE) begin
                spi_enabled_r <= 1'b0;
                close_cnt_r   <= 1'b0;
                state_r       <= ST_CLOSE;
              end else begin
                state_r       <= ST_NEXT;
              end
            end
          end

          ST_CLOSE: begin
            // Hold CS high two cycles so the engine returns to stage 0.
            spi_enabled_r <= 1'b0;
            if (!close_cnt_r) begin
              close_cnt_r <= 1'b1;
            end else begin
              close_cnt_r   <= 1'b0;
              done_r        <= 1'b1;
              busy_r        <= 1'b0;
              spi_data_in_r <= IDLE_BYTE;
              state_r       <= ST_IDLE;
            end
          end

          default: begin
            rd_valid_r    <= 1'b0;
            spi_enabled_r <= 1'b0;
            busy_r        <= 1'b0;
            close_cnt_r   <= 1'b0;
            state_r       <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_reader
// Drives spi_flash_reader against a byte-level SPI engine model and a flash
// model whose memory holds mem[i] = i[7:0]. Expected MOSI streams and read
// data come from a transaction-level model (opcode, address bytes, filler,
// then address+i) built independently of the DUT.
// ----------------------------------------------------------------------------
module tb_spi_flash_reader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] addr = 24'd0;
  logic [15:0] len = 16'd0;
  logic        abort = 1'b0;
  logic        busy, done, rd_valid, spi_enabled, spi_continue_read;
  logic [7:0]  rd_data, spi_data_in;
  logic        rd_ready = 1'b0;
  logic [7:0]  spi_data_out, spi_stage;

  int vectors = 0;
  int miscompares = 0;
  bit rand_mode = 1'b0;

  spi_flash_reader dut (
    .clk_in(clk_in), .reset_n(reset_n), .start(start), .addr(addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .spi_enabled(spi_enabled),
    .spi_data_in(spi_data_in), .spi_continue_read(spi_continue_read),
    .spi_data_out(spi_data_out), .spi_stage(spi_stage)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- SPI byte engine + flash model ----------------
  logic [7:0]  eng_stage = 8'd0;
  logic [7:0]  eng_tx = 8'hFF;
  logic [7:0]  eng_rx = 8'h00;
  logic        eng_run = 1'b0;
  logic        cr_q = 1'b0;
  int          sess_k = 0;
  logic [23:0] fl_addr = 24'd0;
  logic [7:0]  mosi_q[$];

  assign spi_stage    = eng_stage;
  assign spi_data_out = eng_rx;

  always @(posedge clk_in) begin
    cr_q <= spi_continue_read;
    if (!spi_enabled) begin
      eng_stage <= 8'd0;
      eng_run   <= 1'b0;
      sess_k    <= 0;
    end else if (!eng_run) begin
      eng_run   <= 1'b1;
      eng_tx    <= spi_data_in;
      eng_stage <= 8'd1;
    end else if (eng_stage == 8'd99) begin
      if (spi_continue_read && !cr_q) begin
        eng_tx    <= spi_data_in;
        eng_stage <= 8'd1;
      end
    end else if (eng_stage == 8'd16) begin
      eng_stage <= 8'd99;
      mosi_q.push_back(eng_tx);
      if (sess_k >= 1 && sess_k <= 3) fl_addr <= {fl_addr[15:0], eng_tx};
      if (sess_k >= HDR) eng_rx <= 8'(fl_addr + 24'(sess_k - HDR));
      else               eng_rx <= 8'hA5;
      sess_k <= sess_k + 1;
    end else begin
      eng_stage <= eng_stage + 8'd1;
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_q[$];
  int done_cnt = 0;
  int en_cycles = 0;
  int valid_cycles = 0;

  always @(negedge clk_in) begin
    if (rd_valid && rd_ready) got_q.push_back(rd_data);
    if (done)        done_cnt     <= done_cnt + 1;
    if (spi_enabled) en_cycles    <= en_cycles + 1;
    if (rd_valid)    valid_cycles <= valid_cycles + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_data[$];
  int got_base, mosi_base, done_base, en_base, valid_base;

  task automatic build_model(input logic [23:0] a, input logic [15:0] l);
    logic [23:0] t;
    exp_mosi.delete();
    exp_data.delete();
    exp_mosi.push_back(OPC);
    exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);
    exp_mosi.push_back(a[7:0]);
`ifdef SPI_FLASH_FAST_READ_EN
    exp_mosi.push_back(8'hFF);
`endif
    for (int i = 0; i < int'(l); i++) begin
      exp_mosi.push_back(8'hFF);
      t = a + 24'(i);
      exp_data.push_back(t[7:0]);
    end
  endtask

  task automatic mark();
    got_base   = got_q.size();
    mosi_base  = mosi_q.size();
    done_base  = done_cnt;
    en_base    = en_cycles;
    valid_base = valid_cycles;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rand_mode) rd_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    addr  = a;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checks the pulse shape and closed-state outputs.
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, ".done_in_time"}, 32'(n < budget), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, ".cs_high_at_done"}, 32'(spi_enabled), 32'd0);
    tick();
    chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".ndata"}, 32'(got_q.size() - got_base), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++)
      if (got_base + i < got_q.size())
        chk($sformatf("%s.data[%0d]", tag, i), 32'(got_q[got_base + i]), 32'(exp_data[i]));
    chk({tag, ".nmosi"}, 32'(mosi_q.size() - mosi_base), 32'(exp_mosi.size()));
    for (int i = 0; i < exp_mosi.size(); i++)
      if (mosi_base + i < mosi_q.size())
        chk($sformatf("%s.mosi[%0d]", tag, i), 32'(mosi_q[mosi_base + i]), 32'(exp_mosi[i]));
    chk({tag, ".ndone"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  task automatic run_read(input logic [23:0] a, input logic [15:0] l, input string tag);
    build_model(a, l);
    mark();
    do_start(a, l);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(tag, (HDR + int'(l)) * 60 + 100);
    compare_all(tag);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rd_valid && n < 400) begin
      tick();
      n++;
    end
    chk({tag, ".valid_in_time"}, 32'(n < 400), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'h00);
    chk({tag, ".spi_enabled"}, 32'(spi_enabled), 32'd0);
    chk({tag, ".spi_data_in"}, 32'(spi_data_in), 32'hFF);
    chk({tag, ".spi_continue_read"}, 32'(spi_continue_read), 32'd0);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    int          exp_n;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vt[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] held;
    int mosi_hold;
    int unstable;

    vt[0] = '{24'h012345, 16'd4, 4, 8'h45, 8'h48};
    vt[1] = '{24'h0000FE, 16'd3, 3, 8'hFE, 8'h00};
    vt[2] = '{24'hFFFFFF, 16'd2, 2, 8'hFF, 8'h00};
    vt[3] = '{24'h00AB10, 16'd1, 1, 8'h10, 8'h10};
    vt[4] = '{24'h000000, 16'd2, 2, 8'h00, 8'h01};

    // Reset
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Table-driven reads with rd_ready held high
    rd_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      run_read(vt[v].addr, vt[v].len, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d.exp_n", v), 32'(got_q.size() - got_base), 32'(vt[v].exp_n));
      if (got_q.size() > got_base) begin
        chk($sformatf("vec%0d.first", v), 32'(got_q[got_base]), 32'(vt[v].exp_first));
        chk($sformatf("vec%0d.last", v), 32'(got_q[got_q.size() - 1]), 32'(vt[v].exp_last));
      end
    end

    // len == 0: done next cycle, no CS activity, never busy
    mark();
    do_start(24'h123456, 16'd0);
    chk("len0.done", 32'(done), 32'd1);
    chk("len0.busy", 32'(busy), 32'd0);
    tick();
    chk("len0.done_one_cycle", 32'(done), 32'd0);
    repeat (5) tick();
    chk("len0.no_cs", 32'(en_cycles - en_base), 32'd0);
    chk("len0.ndone", 32'(done_cnt - done_base), 32'd1);

    // Consumer stall on byte 2; a start while busy must be ignored
    rd_ready = 1'b0;
    build_model(24'h004000, 16'd3);
    mark();
    do_start(24'h004000, 16'd3);
    wait_valid("stall.b1");
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    wait_valid("stall.b2");
    held      = rd_data;
    mosi_hold = mosi_q.size();
    unstable  = 0;
    addr = 24'h000000; len = 16'd9; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      start = 1'b0;
      if (rd_valid !== 1'b1 || rd_data !== held) unstable++;
    end
    chk("stall.stable", 32'(unstable), 32'd0);
    chk("stall.sck_idle", 32'(mosi_q.size() - mosi_hold), 32'd0);
    chk("stall.engine_parked", 32'(eng_stage), 32'd99);
    rd_ready = 1'b1;
    wait_done("stall", 600);
    compare_all("stall");

    // Abort while the addr[15:8] byte is being shifted
    mark();
    do_start(24'h0A0B0C, 16'd4);
    n = 0;
    while (!(sess_k == 2 && eng_stage >= 8'd1 && eng_stage <= 8'd8) && n < 400) begin
      tick();
      n++;
    end
    chk("abort.reached_byte2", 32'(n < 400), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.cs_high", 32'(spi_enabled), 32'd0);
    wait_done("abort", 50);
    chk("abort.ndone", 32'(done_cnt - done_base), 32'd1);
    chk("abort.no_valid", 32'(valid_cycles - valid_base), 32'd0);
    chk("abort.nmosi", 32'(mosi_q.size() - mosi_base), 32'd2);
    if (mosi_q.size() >= mosi_base + 2) begin
      chk("abort.mosi0", 32'(mosi_q[mosi_base]), 32'(OPC));
      chk("abort.mosi1", 32'(mosi_q[mosi_base + 1]), 32'h0A);
    end
    run_read(24'h000777, 16'd1, "after_abort");

    // Reset in the middle of the data phase
    mark();
    do_start(24'h000100, 16'd4);
    n = 0;
    while (got_q.size() == got_base && n < 400) begin
      tick();
      n++;
    end
    chk("rstmid.first_byte", 32'(n < 400), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("rstmid");
    tick();
    reset_n = 1'b1;
    tick();
    run_read(24'h000200, 16'd2, "after_reset");

    // Randomised reads with random back-pressure
    rand_mode = 1'b1;
    for (int r = 0; r < 12; r++) begin
      run_read(24'($urandom), 16'($urandom_range(1, 5)), $sformatf("rand%0d", r));
    end
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
